// File: rtl/fp_enco_result.sv
// Normalizes, rounds (RNE) and packs a sign/exponent/mantissa triple into an IEEE-754 single.
// Latency 3 cycles, throughput 1/cycle; all stages advance together when the output is free or being taken.
// Backpressure: in_ready = !out_valid | out_ready, and every stage holds otherwise. FP_EXC_FLAGS_EN adds ovf/unf/inexact outputs.
module fp_enco_result #(
    parameter int EXP_IN_W  = 10,
    parameter int MANT_IN_W = 48
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic                 in_zero,
    input  logic [EXP_IN_W-1:0]  in_exp,
    input  logic [MANT_IN_W-1:0] in_mant,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_float
`ifdef FP_EXC_FLAGS_EN
    ,
    output logic                 out_ovf,
    output logic                 out_unf,
    output logic                 out_inexact
`endif
);

    localparam int EW = EXP_IN_W + 1;
    localparam logic [EW-1:0]        EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'(255);
    localparam logic signed [EW-1:0] EXP_MIN = '0;
    // Sticky masks cover everything below the guard bit for the shifted / unshifted cases.
    localparam logic [MANT_IN_W-1:0] STK_SH_MASK = {MANT_IN_W{1'b1}} >> 25;
    localparam logic [MANT_IN_W-1:0] STK_NS_MASK = {MANT_IN_W{1'b1}} >> 26;

    typedef struct packed {
        logic          vld;
        logic          sign;
        logic          zero;
        logic [EW-1:0] exp;
        logic [22:0]   frac;
        logic          grd;
        logic          stk;
    } norm_t;

    typedef struct packed {
        logic          vld;
        logic          sign;
        logic          zero;
        logic [EW-1:0] exp;
        logic [22:0]   frac;
`ifdef FP_EXC_FLAGS_EN
        logic          inexact;
`endif
    } rnd_t;

    logic          adv;
    norm_t         norm_d, norm_q;
    rnd_t          rnd_d, rnd_q;
    logic          out_vld_q;
    logic [31:0]   float_d, float_q;
    logic [EW-1:0] exp_ext;
    logic          rnd_up;
    logic [23:0]   frac_sum;
`ifdef FP_EXC_FLAGS_EN
    logic          ovf_d, ovf_q;
    logic          unf_d, unf_q;
    logic          inx_d, inx_q;
`endif

    assign adv       = !out_vld_q || out_ready;
    assign in_ready  = adv;
    assign out_valid = out_vld_q;
    assign out_float = float_q;
`ifdef FP_EXC_FLAGS_EN
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inx_q;
`endif

    // Stage 1: bring the mantissa into [1,2); the hidden bit is implied and not carried further.
    always_comb begin
        exp_ext     = {in_exp[EXP_IN_W-1], in_exp};
        norm_d      = '0;
        norm_d.vld  = in_valid;
        norm_d.sign = in_sign;
        norm_d.zero = in_zero;
        if (in_mant[MANT_IN_W-1]) begin
            norm_d.exp  = exp_ext + EXP_ONE;
            norm_d.frac = in_mant[MANT_IN_W-2 -: 23];
            norm_d.grd  = in_mant[MANT_IN_W-25];
            norm_d.stk  = |(in_mant & STK_SH_MASK);
        end else begin
            norm_d.exp  = exp_ext;
            norm_d.frac = in_mant[MANT_IN_W-3 -: 23];
            norm_d.grd  = in_mant[MANT_IN_W-26];
            norm_d.stk  = |(in_mant & STK_NS_MASK);
        end
    end

    // Stage 2: round to nearest even; a carry out of the fraction means 1.0 at the next exponent.
    always_comb begin
        rnd_d      = '0;
        rnd_d.vld  = norm_q.vld;
        rnd_d.sign = norm_q.sign;
        rnd_d.zero = norm_q.zero;
        rnd_up     = norm_q.grd & (norm_q.stk | norm_q.frac[0]);
        frac_sum   = {1'b0, norm_q.frac} + {23'd0, rnd_up};
        rnd_d.frac = frac_sum[22:0];
        if (frac_sum[23]) begin
            rnd_d.exp = norm_q.exp + EXP_ONE;
        end else begin
            rnd_d.exp = norm_q.exp;
        end
`ifdef FP_EXC_FLAGS_EN
        rnd_d.inexact = norm_q.grd | norm_q.stk;
`endif
    end

    // Stage 3: range check on the post-round exponent; no subnormals, NaN never produced.
    always_comb begin
        float_d = '0;
`ifdef FP_EXC_FLAGS_EN
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = rnd_q.vld & !rnd_q.zero & rnd_q.inexact;
`endif
        if (rnd_q.zero) begin
            float_d = {rnd_q.sign, 31'h0};
        end else if ($signed(rnd_q.exp) >= EXP_MAX) begin
            float_d = {rnd_q.sign, 8'hFF, 23'h0};
`ifdef FP_EXC_FLAGS_EN
            ovf_d = rnd_q.vld;
`endif
        end else if ($signed(rnd_q.exp) <= EXP_MIN) begin
            float_d = {rnd_q.sign, 31'h0};
`ifdef FP_EXC_FLAGS_EN
            unf_d = rnd_q.vld;
`endif
        end else begin
            float_d = {rnd_q.sign, rnd_q.exp[7:0], rnd_q.frac};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            norm_q    <= '0;
            rnd_q     <= '0;
            out_vld_q <= 1'b0;
            float_q   <= 32'h0;
`ifdef FP_EXC_FLAGS_EN
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inx_q     <= 1'b0;
`endif
        end else if (adv) begin
            norm_q    <= norm_d;
            rnd_q     <= rnd_d;
            out_vld_q <= rnd_q.vld;
            float_q   <= float_d;
`ifdef FP_EXC_FLAGS_EN
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inx_q     <= inx_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_enco_result.sv
// Directed bench for fp_enco_result: scoreboarded results, latency, backpressure hold and mid-flight reset.
module tb_fp_enco_result;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sign, in_zero;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid, out_ready;
    logic [31:0] out_float;
`ifdef FP_EXC_FLAGS_EN
    logic        out_ovf, out_unf, out_inexact;
`endif

    int          checks = 0;
    int          errors = 0;
    int          popped = 0;
    logic [34:0] exp_in;
    logic [34:0] mon_e;
    logic [34:0] sb[$];
    logic        stall_prev = 1'b0;
    logic [31:0] held = '0;

    always #5 clk = ~clk;

    fp_enco_result dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_zero(in_zero), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float)
`ifdef FP_EXC_FLAGS_EN
        , .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Scoreboard: handshakes are decided at the next rising edge, so sample mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) sb.push_back(exp_in);
            if (out_valid) begin
                if (stall_prev) check("hold", out_float, held);
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        check("out_when_empty", out_valid, 1'b0);
                    end else begin
                        mon_e = sb.pop_front();
                        popped++;
                        check("result", out_float, mon_e[31:0]);
`ifdef FP_EXC_FLAGS_EN
                        check("flags", {out_ovf, out_unf, out_inexact}, mon_e[34:32]);
`endif
                    end
                end
                stall_prev = !out_ready;
                held       = out_float;
            end else begin
                stall_prev = 1'b0;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic s, input logic z, input logic [9:0] e,
                        input logic [47:0] m, input logic [34:0] w);
        logic acc;
        in_sign = s; in_zero = z; in_exp = e; in_mant = m; exp_in = w; in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", acc, 1'b1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int p0;
        int stale;
        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_zero = 1'b0;
        in_exp = '0; in_mant = '0; out_ready = 1'b1; exp_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_float", out_float, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: 2.25 should appear three edges after acceptance.
        in_sign = 1'b0; in_zero = 1'b0; in_exp = 10'd127; in_mant = 48'h900000000000;
        exp_in = {3'b000, 32'h40100000}; in_valid = 1'b1;
        lat = 0;
        while (lat < 20 && !(lat > 0 && out_valid)) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
        end
        check("latency", lat, 3);
        drain();

        // Directed vectors, back to back; flags are {ovf, unf, inexact}.
        send(0, 0, 10'd127,  48'h400000400000, {3'b001, 32'h3F800000});
        send(0, 0, 10'd127,  48'h400000C00000, {3'b001, 32'h3F800002});
        send(0, 0, 10'd127,  48'h7FFFFFC00000, {3'b001, 32'h40000000});
        send(1, 0, 10'd254,  48'h800000000000, {3'b100, 32'hFF800000});
        send(0, 0, 10'd0,    48'h400000000000, {3'b010, 32'h00000000});
        send(1, 1, 10'd254,  48'h800000000000, {3'b000, 32'h80000000});
        send(0, 0, 10'd127,  48'h400000400001, {3'b001, 32'h3F800001});
        send(0, 0, 10'd254,  48'h7FFFFFC00000, {3'b101, 32'h7F800000});
        send(0, 0, 10'd254,  48'h7FFFFF800000, {3'b000, 32'h7F7FFFFF});
        send(0, 0, 10'd0,    48'h800000000000, {3'b000, 32'h00800000});
        send(1, 0, 10'h3FB,  48'h400000000000, {3'b010, 32'h80000000});
        send(0, 0, 10'd1,    48'h7FFFFFFFFFFF, {3'b001, 32'h01000000});
        send(0, 0, 10'd127,  48'h800001800000, {3'b001, 32'h40000002});
        send(0, 0, 10'd127,  48'h800000800000, {3'b001, 32'h40000000});
        drain();

        // Backpressure: out_ready low in cycles 2..6 while six inputs stream in.
        p0 = popped;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(0, 0, 10'(120 + i), 48'h400000000000,
                         {3'b000, 1'b0, 8'(120 + i), 23'h0});
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 2 && c <= 6);
                    @(negedge clk);
                    if (c == 4) check("stall_in_ready", in_ready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", popped - p0, 6);

        // Reset with three entries in flight.
        send(0, 0, 10'd127, 48'h400000000000, {3'b000, 32'h3F800000});
        send(0, 0, 10'd128, 48'h400000000000, {3'b000, 32'h40000000});
        send(0, 0, 10'd129, 48'h400000000000, {3'b000, 32'h40800000});
        in_valid = 1'b0;
        check("pre_reset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_float", out_float, 32'h0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("stale_after_reset", stale, 0);
        check("post_rst_in_ready", in_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
